// File: rtl/register_bank.sv
// Architectural register file with write-through bypass and a register dump engine.
// Ports:
//   i_clock, i_reset            rising-edge clock, synchronous active-high reset
//   i_reg_write/_addr/_data     write-back port (r0 and out-of-range writes dropped)
//   i_read_addr_a/b, o_read_*   two combinational read ports with same-cycle bypass
//   i_dump_start, i_dump_ready  dump request and consumer acceptance
//   o_dump_valid/_addr/_data    presented dump word (registered)
//   o_dump_busy, o_dump_done    engine active (SEND/DONE), one-cycle completion pulse
module register_bank #(
    parameter int PROC_BITS      = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int NUM_REGS       = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_reg_write,
    input  logic [REG_ADDRS_BITS-1:0] i_write_addr,
    input  logic [PROC_BITS-1:0]      i_write_data,
    input  logic [REG_ADDRS_BITS-1:0] i_read_addr_a,
    input  logic [REG_ADDRS_BITS-1:0] i_read_addr_b,
    output logic [PROC_BITS-1:0]      o_read_data_a,
    output logic [PROC_BITS-1:0]      o_read_data_b,
    input  logic                      i_dump_start,
    input  logic                      i_dump_ready,
    output logic                      o_dump_valid,
    output logic [REG_ADDRS_BITS-1:0] o_dump_addr,
    output logic [PROC_BITS-1:0]      o_dump_data,
    output logic                      o_dump_busy,
    output logic                      o_dump_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [REG_ADDRS_BITS:0]   NUM_REGS_W = (REG_ADDRS_BITS+1)'(NUM_REGS);
    localparam logic [REG_ADDRS_BITS-1:0] LAST_IDX   = REG_ADDRS_BITS'(NUM_REGS - 1);

    logic [PROC_BITS-1:0]      r_regs [NUM_REGS];
    logic [1:0]                r_state;
    logic [REG_ADDRS_BITS-1:0] r_idx;
    logic [PROC_BITS-1:0]      r_dump_data;
    logic                      r_dump_valid;

    logic                      w_wr_en;
    logic [PROC_BITS-1:0]      w_rd_a;
    logic [PROC_BITS-1:0]      w_rd_b;
    logic [REG_ADDRS_BITS-1:0] w_next_idx;
    logic [PROC_BITS-1:0]      w_next_word;

    function automatic logic in_range(input logic [REG_ADDRS_BITS-1:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    // Only writes that actually change state are visible to the bypass paths.
    assign w_wr_en = i_reg_write && (i_write_addr != '0) && in_range(i_write_addr);

    always_comb begin
        w_rd_a = '0;
        if ((i_read_addr_a != '0) && in_range(i_read_addr_a)) begin
            if (w_wr_en && (i_write_addr == i_read_addr_a)) begin
                w_rd_a = i_write_data;
            end else begin
                w_rd_a = r_regs[i_read_addr_a];
            end
        end
    end

    always_comb begin
        w_rd_b = '0;
        if ((i_read_addr_b != '0) && in_range(i_read_addr_b)) begin
            if (w_wr_en && (i_write_addr == i_read_addr_b)) begin
                w_rd_b = i_write_data;
            end else begin
                w_rd_b = r_regs[i_read_addr_b];
            end
        end
    end

    // Word loaded on an accepting edge; a write landing on that same edge wins.
    assign w_next_idx = r_idx + 1'b1;

    always_comb begin
        w_next_word = '0;
        if ((w_next_idx != '0) && in_range(w_next_idx)) begin
            if (w_wr_en && (i_write_addr == w_next_idx)) begin
                w_next_word = i_write_data;
            end else begin
                w_next_word = r_regs[w_next_idx];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_write_addr] <= i_write_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_dump_start) begin
                        r_state      <= S_SEND;
                        r_idx        <= '0;
                        r_dump_data  <= '0;
                        r_dump_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (i_dump_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state      <= S_DONE;
                            r_idx        <= '0;
                            r_dump_valid <= 1'b0;
                        end else begin
                            r_idx       <= w_next_idx;
                            r_dump_data <= w_next_word;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dump_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_read_data_a = w_rd_a;
    assign o_read_data_b = w_rd_b;
    assign o_dump_valid  = r_dump_valid;
    assign o_dump_addr   = r_idx;
    assign o_dump_data   = r_dump_data;
    assign o_dump_busy   = (r_state == S_SEND) || (r_state == S_DONE);
    assign o_dump_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank.
// Transaction-level model plus directed scenarios with literal expectations.
module tb_register_bank;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_reg_write;
    logic [4:0]  i_write_addr;
    logic [31:0] i_write_data;
    logic [4:0]  i_read_addr_a;
    logic [4:0]  i_read_addr_b;
    logic [31:0] o_read_data_a;
    logic [31:0] o_read_data_b;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [4:0]  o_dump_addr;
    logic [31:0] o_dump_data;
    logic        o_dump_busy;
    logic        o_dump_done;

    register_bank dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_reg_write   (i_reg_write),
        .i_write_addr  (i_write_addr),
        .i_write_data  (i_write_data),
        .i_read_addr_a (i_read_addr_a),
        .i_read_addr_b (i_read_addr_b),
        .o_read_data_a (o_read_data_a),
        .o_read_data_b (o_read_data_b),
        .i_dump_start  (i_dump_start),
        .i_dump_ready  (i_dump_ready),
        .o_dump_valid  (o_dump_valid),
        .o_dump_addr   (o_dump_addr),
        .o_dump_data   (o_dump_data),
        .o_dump_busy   (o_dump_busy),
        .o_dump_done   (o_dump_done)
    );

    always #5 i_clock = ~i_clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents and the dump as a transaction stream.
    logic [31:0] m_regs [32];
    bit          dm_active = 0;
    bit          dm_done   = 0;
    int          dm_idx    = 0;
    logic [31:0] dm_word   = '0;
    bit          chk_en    = 0;

    always @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            dm_active = 0;
            dm_done   = 0;
            dm_idx    = 0;
        end else begin
            if (i_reg_write && i_write_addr != 0) m_regs[i_write_addr] = i_write_data;
            if (dm_done) begin
                dm_done = 0;
            end else if (!dm_active) begin
                if (i_dump_start) begin
                    dm_active = 1;
                    dm_idx    = 0;
                    dm_word   = '0;
                end
            end else if (i_dump_ready) begin
                if (dm_idx == 31) begin
                    dm_active = 0;
                    dm_done   = 1;
                end else begin
                    dm_idx++;
                    dm_word = m_regs[dm_idx];
                end
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return '0;
        if (i_reg_write && i_write_addr == a) return i_write_data;
        return m_regs[a];
    endfunction

    int          done_cnt = 0;
    logic [4:0]  acc_addr [$];
    logic [31:0] acc_data [$];

    always @(negedge i_clock) begin
        if (chk_en) begin
            check("rd_a", o_read_data_a, m_read(i_read_addr_a));
            check("rd_b", o_read_data_b, m_read(i_read_addr_b));
            check("valid", 32'(o_dump_valid), 32'(dm_active));
            check("busy", 32'(o_dump_busy), 32'(dm_active || dm_done));
            check("done", 32'(o_dump_done), 32'(dm_done));
            if (dm_active) begin
                check("dump_addr", 32'(o_dump_addr), 32'(dm_idx));
                check("dump_data", o_dump_data, dm_word);
            end
            if (o_dump_done) done_cnt++;
            if (o_dump_valid && i_dump_ready && !i_reset) begin
                acc_addr.push_back(o_dump_addr);
                acc_data.push_back(o_dump_data);
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #2;
    endtask

    task automatic settle();
        @(negedge i_clock);
        #1;
    endtask

    task automatic clear_log();
        acc_addr.delete();
        acc_data.delete();
        done_cnt = 0;
    endtask

    // Runs until one done pulse; toggle selects ready pattern 1,0,0,1,...
    task automatic run_until_done(input bit toggle, input string name);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 400) begin
            i_dump_ready = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            tick();
            cyc++;
        end
        check(name, 32'(done_cnt), 32'd1);
        i_dump_ready = 1'b1;
        tick();
        tick();
        check({name, "_once"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_log(input logic [31:0] exp_w [32], input string name);
        check({name, "_count"}, 32'(acc_addr.size()), 32'd32);
        for (int i = 0; i < 32 && i < acc_addr.size(); i++) begin
            check({name, "_addr"}, 32'(acc_addr[i]), 32'(i));
            check({name, "_data"}, acc_data[i], exp_w[i]);
        end
    endtask

    logic [31:0] exp_w [32];

    initial begin
        i_reset       = 1'b1;
        i_reg_write   = 1'b0;
        i_write_addr  = '0;
        i_write_data  = '0;
        i_read_addr_a = 5'd5;
        i_read_addr_b = 5'd31;
        i_dump_start  = 1'b0;
        i_dump_ready  = 1'b0;
        tick();
        tick();
        chk_en  = 1;
        i_reset = 1'b0;
        settle();
        check("reset_rd_a", o_read_data_a, 32'h0);
        check("reset_rd_b", o_read_data_b, 32'h0);
        check("reset_valid", 32'(o_dump_valid), 32'd0);
        check("reset_dump_data", o_dump_data, 32'h0);
        check("reset_dump_addr", 32'(o_dump_addr), 32'd0);

        // Test 1: write then read; r0 is hardwired to zero.
        i_reg_write  = 1'b1;
        i_write_addr = 5'd5;
        i_write_data = 32'hDEADBEEF;
        i_read_addr_a = 5'd0;
        tick();
        i_reg_write   = 1'b0;
        i_read_addr_a = 5'd5;
        settle();
        check("t1_r5", o_read_data_a, 32'hDEADBEEF);
        i_reg_write   = 1'b1;
        i_write_addr  = 5'd0;
        i_write_data  = 32'h1234;
        i_read_addr_a = 5'd0;
        settle();
        check("t1_r0_bypass", o_read_data_a, 32'h0);
        tick();
        i_reg_write = 1'b0;
        settle();
        check("t1_r0", o_read_data_a, 32'h0);

        // Test 2: same-cycle write is visible on both ports.
        i_reg_write   = 1'b1;
        i_write_addr  = 5'd7;
        i_write_data  = 32'hA5A5A5A5;
        i_read_addr_a = 5'd7;
        i_read_addr_b = 5'd7;
        settle();
        check("t2_a", o_read_data_a, 32'hA5A5A5A5);
        check("t2_b", o_read_data_b, 32'hA5A5A5A5);
        tick();
        i_reg_write = 1'b0;

        // Test 3: full-throughput dump of rN = N*3.
        for (int n = 1; n < 32; n++) begin
            i_reg_write  = 1'b1;
            i_write_addr = 5'(n);
            i_write_data = 32'(n * 3);
            tick();
        end
        i_reg_write = 1'b0;
        for (int n = 0; n < 32; n++) exp_w[n] = 32'(n * 3);
        clear_log();
        i_dump_ready = 1'b1;
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        settle();
        check("t3_first_valid", 32'(o_dump_valid), 32'd1);
        run_until_done(1'b0, "t3_done");
        check_log(exp_w, "t3");

        // Test 4: back-pressure 1,0,0,1 pattern.
        clear_log();
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        run_until_done(1'b1, "t4_done");
        check_log(exp_w, "t4");

        // Test 5: writes during the dump, including one on a load edge.
        clear_log();
        i_dump_ready = 1'b1;
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        repeat (3) tick();
        i_reg_write  = 1'b1;
        i_write_addr = 5'd10;
        i_write_data = 32'h55;
        tick();
        i_write_addr = 5'd2;
        i_write_data = 32'h77;
        tick();
        i_reg_write = 1'b0;
        repeat (14) tick();
        i_reg_write  = 1'b1;
        i_write_addr = 5'd20;
        i_write_data = 32'h2020;
        tick();
        i_reg_write = 1'b0;
        run_until_done(1'b0, "t5_done");
        exp_w[10] = 32'h55;
        exp_w[20] = 32'h2020;
        check_log(exp_w, "t5");
        if (acc_data.size() == 32) begin
            check("t5_word10", acc_data[10], 32'h55);
            check("t5_word2", acc_data[2], 32'd6);
        end
        i_read_addr_a = 5'd2;
        settle();
        check("t5_r2", o_read_data_a, 32'h77);

        // Test 6: reset aborts a dump at word 12.
        clear_log();
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        repeat (12) tick();
        settle();
        check("t6_word12", 32'(o_dump_addr), 32'd12);
        i_reset = 1'b1;
        tick();
        i_reset       = 1'b0;
        i_read_addr_a = 5'd1;
        i_read_addr_b = 5'd5;
        settle();
        check("t6_valid", 32'(o_dump_valid), 32'd0);
        check("t6_busy", 32'(o_dump_busy), 32'd0);
        check("t6_r1", o_read_data_a, 32'h0);
        check("t6_r5", o_read_data_b, 32'h0);
        repeat (40) tick();
        check("t6_no_done", 32'(done_cnt), 32'd0);

        // Start held high restarts the dump once back in IDLE.
        clear_log();
        i_dump_start = 1'b1;
        repeat (70) tick();
        i_dump_start = 1'b0;
        check("restart_done", 32'(done_cnt), 32'd2);
        repeat (40) tick();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
